ahb_slave_if: RTL and testbench
===============================

Name: ahb_slave_if

Overview:
- AHB-side front end of the AHB-to-APB bridge; sits directly upstream of the bridge APB control FSM.
- Qualifies AHB transfers into `Valid` and decodes the target APB slave into `Temp_selx`.
- Pipelines address, write data and direction into the 3-deep and 2-deep register sets the FSM consumes.
- Generates the two-cycle AHB ERROR response for unmapped addresses.

Parameters:
- SLV0_BASE, 32'h8000_0000, base of APB slave 0 window
- SLV1_BASE, 32'h8400_0000, base of APB slave 1 window
- SLV2_BASE, 32'h8800_0000, base of APB slave 2 window
- WIN_SIZE, 32'h0400_0000, size of each window (power of two)

Ports:
- Hclk  in  1  bridge clock, all logic on rising edge
- Hresetn  in  1  synchronous, active-high reset (1 = reset)
- Hwrite  in  1  AHB direction, 1 = write
- Hreadyin  in  1  AHB bus HREADY; pipeline advances only when 1
- Htrans  in  2  AHB transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- Hburst  in  3  AHB burst type; used only with the optional feature
- Haddr  in  32  AHB address phase address
- Hwdata  in  32  AHB write data, one cycle after its address
- Valid  out  1  qualified transfer this cycle (combinational)
- Temp_selx  out  3  one-hot APB slave select decoded from Haddr (combinational)
- Haddr_1, Haddr_2, Haddr_3  out  32 each  address pipeline, stages 1..3
- HWdata_1, HWdata_2, HWdata_3  out  32 each  write-data pipeline, stages 1..3
- Hwritereg, Hwritereg_2  out  1 each  Hwrite delayed 1 and 2 cycles
- Hresp  out  2  AHB response: 00 OKAY, 01 ERROR
- Hreadyout_err  out  1  HREADY contribution of this block; 0 in first error cycle
- Burst_err  out  1  sticky burst protocol error (optional feature)

Behaviour:
- Reset (Hresetn=1 at a clock edge): all pipeline registers, Hwritereg, Hwritereg_2 and Burst_err <= 0; error FSM <= OKAY; Hresp=00; Hreadyout_err=1.
- Decode, combinational:
  - Haddr in [SLV0_BASE, SLV0_BASE+WIN_SIZE) -> Temp_selx=001
  - SLV1 window -> 010
  - SLV2 window -> 100
  - otherwise 000 (unmapped)
- Valid = Hreadyin & Htrans[1] & (Temp_selx != 0) & (error FSM == OKAY). IDLE and BUSY never produce Valid.
- Pipeline, on every edge with Hreadyin=1 and not in reset:
  - Haddr_1<=Haddr, Haddr_2<=Haddr_1, Haddr_3<=Haddr_2
  - HWdata_1<=Hwdata, HWdata_2<=HWdata_1, HWdata_3<=HWdata_2
  - Hwritereg<=Hwrite, Hwritereg_2<=Hwritereg
  - Hreadyin=0: all stages hold.
  - Latency: Haddr appears on Haddr_1 one cycle after its address phase, on Haddr_3 three cycles after.
- Error FSM states: OKAY, ERR1, ERR2.
  - OKAY -> ERR1 when Hreadyin & Htrans[1] & Temp_selx==000.
  - ERR1: Hresp=01, Hreadyout_err=0; always -> ERR2.
  - ERR2: Hresp=01, Hreadyout_err=1; always -> OKAY.
  - OKAY: Hresp=00, Hreadyout_err=1.
  - Transfers presented during ERR1/ERR2 give Valid=0 and do not re-trigger the FSM.
  - An unmapped transfer in the cycle after ERR2 re-enters ERR1.
- Simultaneous events: reset wins over every other action, including mid-ERR1 (FSM -> OKAY next cycle).

Optional Feature:
- Macro AHB_BURST_CHECK_EN.
- When defined:
  - A 5-bit beat counter loads 1 on each Valid NONSEQ and increments on each Valid SEQ.
  - Burst_err is set and held until reset on either of:
    - a Valid SEQ with the counter at 0 (no preceding NONSEQ);
    - a beat count exceeding the Hburst length (INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16; SINGLE=1; INCR unlimited).
  - The counter clears to 0 on IDLE with Hreadyin=1.
  - Burst_err does not affect Valid.
- When undefined: no counter logic; Burst_err tied 0; Hburst unused.

Test Plan:
- Reset: assert Hresetn=1 for 2 cycles with random inputs -> all pipeline outputs 0, Hresp=00, Hreadyout_err=1, Burst_err=0.
- Single write: NONSEQ, Hwrite=1, Haddr=32'h8000_0010, then Hwdata=32'hDEAD_BEEF -> Valid=1, Temp_selx=001 in the address cycle; next cycle Haddr_1=32'h8000_0010, Hwritereg=1; following cycle HWdata_1=32'hDEAD_BEEF, Haddr_2=32'h8000_0010.
- Wait-state hold: Hreadyin=0 for 3 cycles mid-burst at addresses 32'h8400_0000/04 -> Haddr_1..3 and HWdata_1..3 unchanged, Valid=0; values resume shifting when Hreadyin=1.
- Unmapped access: NONSEQ to 32'h9000_0000 -> Valid=0, Temp_selx=000; next cycle Hresp=01 with Hreadyout_err=0; then Hresp=01 with Hreadyout_err=1; then Hresp=00. A NONSEQ to 32'h8800_0000 during ERR1 gives Valid=0.
- Decode boundaries: 32'h83FF_FFFC -> 001; 32'h8400_0000 -> 010; 32'h8BFF_FFFC -> 100; 32'h8C00_0000 -> 000 plus ERROR.
- With AHB_BURST_CHECK_EN defined:
  - INCR4 with NONSEQ + 4 SEQ beats -> Burst_err=1 after the 5th beat.
  - Fresh SEQ after reset -> Burst_err=1.
  - Correct INCR4 -> Burst_err=0.

Source files
------------

// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge: transfer qualification, slave decode,
// address/data/direction pipelines and the two-cycle ERROR response. Optional: AHB_BURST_CHECK_EN.
module ahb_slave_if #(
    parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
    parameter logic [31:0] WIN_SIZE  = 32'h0400_0000
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [2:0]  Hburst,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    output logic        Valid,
    output logic [2:0]  Temp_selx,
    output logic [31:0] Haddr_1,
    output logic [31:0] Haddr_2,
    output logic [31:0] Haddr_3,
    output logic [31:0] HWdata_1,
    output logic [31:0] HWdata_2,
    output logic [31:0] HWdata_3,
    output logic        Hwritereg,
    output logic        Hwritereg_2,
    output logic [1:0]  Hresp,
    output logic        Hreadyout_err,
    output logic        Burst_err
);

    typedef enum logic [1:0] {OKAY = 2'd0, ERR1 = 2'd1, ERR2 = 2'd2} err_state_t;

    err_state_t  state;
    logic [31:0] off0, off1, off2;
    logic        err_hit;

    // Unsigned offset compare keeps each window check to a single subtract.
    assign off0 = Haddr - SLV0_BASE;
    assign off1 = Haddr - SLV1_BASE;
    assign off2 = Haddr - SLV2_BASE;

    always_comb begin
        Temp_selx = 3'b000;
        if (off0 < WIN_SIZE)      Temp_selx = 3'b001;
        else if (off1 < WIN_SIZE) Temp_selx = 3'b010;
        else if (off2 < WIN_SIZE) Temp_selx = 3'b100;
    end

    assign Valid   = Hreadyin & Htrans[1] & (Temp_selx != 3'b000) & (state == OKAY);
    assign err_hit = Hreadyin & Htrans[1] & (Temp_selx == 3'b000) & (state == OKAY);

    always_ff @(posedge Hclk) begin
        if (Hresetn) begin
            Haddr_1     <= '0;
            Haddr_2     <= '0;
            Haddr_3     <= '0;
            HWdata_1    <= '0;
            HWdata_2    <= '0;
            HWdata_3    <= '0;
            Hwritereg   <= 1'b0;
            Hwritereg_2 <= 1'b0;
        end else if (Hreadyin) begin
            Haddr_1     <= Haddr;
            Haddr_2     <= Haddr_1;
            Haddr_3     <= Haddr_2;
            HWdata_1    <= Hwdata;
            HWdata_2    <= HWdata_1;
            HWdata_3    <= HWdata_2;
            Hwritereg   <= Hwrite;
            Hwritereg_2 <= Hwritereg;
        end
    end

    // Response outputs are registered alongside the state so they reflect the current state.
    always_ff @(posedge Hclk) begin
        if (Hresetn) begin
            state         <= OKAY;
            Hresp         <= 2'b00;
            Hreadyout_err <= 1'b1;
        end else begin
            case (state)
                OKAY: begin
                    if (err_hit) begin
                        state         <= ERR1;
                        Hresp         <= 2'b01;
                        Hreadyout_err <= 1'b0;
                    end
                end
                ERR1: begin
                    state         <= ERR2;
                    Hresp         <= 2'b01;
                    Hreadyout_err <= 1'b1;
                end
                default: begin
                    state         <= OKAY;
                    Hresp         <= 2'b00;
                    Hreadyout_err <= 1'b1;
                end
            endcase
        end
    end

`ifdef AHB_BURST_CHECK_EN
    logic [4:0] beat_cnt;
    logic [4:0] beat_next;
    logic [4:0] beat_limit;

    // Beat limit per Hburst encoding; 0 means unlimited (INCR).
    function automatic logic [4:0] burst_limit(input logic [2:0] hb);
        case (hb)
            3'b000:          return 5'd1;
            3'b010, 3'b011:  return 5'd4;
            3'b100, 3'b101:  return 5'd8;
            3'b110, 3'b111:  return 5'd16;
            default:         return 5'd0;
        endcase
    endfunction

    // Saturate so a long INCR burst cannot wrap back to a "no NONSEQ" count.
    assign beat_next  = (beat_cnt == 5'd31) ? beat_cnt : beat_cnt + 5'd1;
    assign beat_limit = burst_limit(Hburst);

    always_ff @(posedge Hclk) begin
        if (Hresetn) begin
            beat_cnt  <= '0;
            Burst_err <= 1'b0;
        end else if (Valid && Htrans == 2'b10) begin
            beat_cnt <= 5'd1;
        end else if (Valid && Htrans == 2'b11) begin
            if (beat_cnt == 5'd0) begin
                Burst_err <= 1'b1;
            end else begin
                beat_cnt <= beat_next;
                if (beat_limit != 5'd0 && beat_next > beat_limit) Burst_err <= 1'b1;
            end
        end else if (Hreadyin && Htrans == 2'b00) begin
            beat_cnt <= '0;
        end
    end
`else
    logic unused_hburst;

    // Burst type only matters to the burst checker.
    assign unused_hburst = ^Hburst;
    assign Burst_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
module tb_ahb_slave_if;

  logic        Hclk, Hresetn, Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [2:0]  Hburst;
  logic [31:0] Haddr, Hwdata;
  logic        Valid;
  logic [2:0]  Temp_selx;
  logic [31:0] Haddr_1, Haddr_2, Haddr_3, HWdata_1, HWdata_2, HWdata_3;
  logic        Hwritereg, Hwritereg_2;
  logic [1:0]  Hresp;
  logic        Hreadyout_err, Burst_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] ha[$];
  logic [31:0] hw[$];
  logic        hr[$];
  int          rq[$];
  int          cur;
  logic [2:0]  burst;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

  ahb_slave_if dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Hburst(Hburst), .Haddr(Haddr), .Hwdata(Hwdata),
    .Valid(Valid), .Temp_selx(Temp_selx),
    .Haddr_1(Haddr_1), .Haddr_2(Haddr_2), .Haddr_3(Haddr_3),
    .HWdata_1(HWdata_1), .HWdata_2(HWdata_2), .HWdata_3(HWdata_3),
    .Hwritereg(Hwritereg), .Hwritereg_2(Hwritereg_2),
    .Hresp(Hresp), .Hreadyout_err(Hreadyout_err), .Burst_err(Burst_err)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
    if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
    if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
    return 3'b000;
  endfunction

  task automatic check_pipe();
    total++;
    if (Haddr_1 !== ha[2]) begin bad++; $error("FAIL haddr_1: got %0h want %0h", Haddr_1, ha[2]); end
    total++;
    if (Haddr_2 !== ha[1]) begin bad++; $error("FAIL haddr_2: got %0h want %0h", Haddr_2, ha[1]); end
    total++;
    if (Haddr_3 !== ha[0]) begin bad++; $error("FAIL haddr_3: got %0h want %0h", Haddr_3, ha[0]); end
    total++;
    if (HWdata_1 !== hw[2]) begin bad++; $error("FAIL hwdata_1: got %0h want %0h", HWdata_1, hw[2]); end
    total++;
    if (HWdata_2 !== hw[1]) begin bad++; $error("FAIL hwdata_2: got %0h want %0h", HWdata_2, hw[1]); end
    total++;
    if (HWdata_3 !== hw[0]) begin bad++; $error("FAIL hwdata_3: got %0h want %0h", HWdata_3, hw[0]); end
    total++;
    if (Hwritereg !== hr[2]) begin bad++; $error("FAIL hwritereg: got %0h want %0h", Hwritereg, hr[2]); end
    total++;
    if (Hwritereg_2 !== hr[1]) begin bad++; $error("FAIL hwritereg_2: got %0h want %0h", Hwritereg_2, hr[1]); end
  endtask

  task automatic check_resp();
    logic [1:0] er;
    logic       eh;
    er = (cur == 0) ? 2'b00 : 2'b01;
    eh = (cur != 1);
    total++;
    if (Hresp !== er) begin bad++; $error("FAIL hresp: got %0h want %0h", Hresp, er); end
    total++;
    if (Hreadyout_err !== eh) begin bad++; $error("FAIL hreadyout_err: got %0h want %0h", Hreadyout_err, eh); end
  endtask

  task automatic do_reset(input int n);
    Hresetn  = 1'b1;
    Hreadyin = 1'($urandom);
    Htrans   = 2'($urandom);
    Hwrite   = 1'($urandom);
    Haddr    = $urandom;
    Hwdata   = $urandom;
    Hburst   = 3'($urandom);
    repeat (n) @(posedge Hclk);
    #1;
    Hresetn = 1'b0;
    ha.delete(); hw.delete(); hr.delete(); rq.delete();
    repeat (3) begin ha.push_back('0); hw.push_back('0); hr.push_back(1'b0); end
    cur = 0;
    check_pipe();
    check_resp();
    total++;
    if (Burst_err !== 1'b0) begin bad++; $error("FAIL burst_err_rst: got %0h want 0", Burst_err); end
  endtask

  task automatic step(input logic rdy, input logic [1:0] tr, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    logic [2:0] es;
    logic       ev;
    Hreadyin = rdy; Htrans = tr; Hwrite = w; Haddr = a; Hwdata = d; Hburst = burst;
    #1;
    es = exp_sel(a);
    ev = rdy & tr[1] & (es != 3'b000) & (cur == 0);
    total++;
    if (Temp_selx !== es) begin bad++; $error("FAIL temp_selx: got %0h want %0h", Temp_selx, es); end
    total++;
    if (Valid !== ev) begin bad++; $error("FAIL valid: got %0h want %0h", Valid, ev); end
    check_resp();
    if (rdy && tr[1] && es == 3'b000 && cur == 0) begin
      rq.push_back(1);
      rq.push_back(2);
    end
    if (rdy) begin
      ha.push_back(a); hw.push_back(d); hr.push_back(w);
    end
    @(posedge Hclk);
    #1;
    while (ha.size() > 3) begin
      void'(ha.pop_front()); void'(hw.pop_front()); void'(hr.pop_front());
    end
    cur = (rq.size() > 0) ? rq.pop_front() : 0;
    check_pipe();
`ifndef AHB_BURST_CHECK_EN
    total++;
    if (Burst_err !== 1'b0) begin bad++; $error("FAIL burst_err_off: got %0h want 0", Burst_err); end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] pool [6];

  initial begin
    burst = 3'b001;
    Hresetn = 1'b1; Hreadyin = 1'b0; Htrans = IDLE; Hwrite = 1'b0;
    Haddr = '0; Hwdata = '0; Hburst = '0;
    @(posedge Hclk); #1;

    // Reset with random inputs
    do_reset(2);

    // Single write
    step(1'b1, NSEQ, 1'b1, 32'h8000_0010, 32'h0);
    total++;
    if (Haddr_1 !== 32'h8000_0010) begin bad++; $error("FAIL sw_haddr_1: got %0h want 80000010", Haddr_1); end
    total++;
    if (Hwritereg !== 1'b1) begin bad++; $error("FAIL sw_hwritereg: got %0h want 1", Hwritereg); end
    step(1'b1, IDLE, 1'b0, 32'h0, 32'hDEAD_BEEF);
    total++;
    if (HWdata_1 !== 32'hDEAD_BEEF) begin bad++; $error("FAIL sw_hwdata_1: got %0h want deadbeef", HWdata_1); end
    total++;
    if (Haddr_2 !== 32'h8000_0010) begin bad++; $error("FAIL sw_haddr_2: got %0h want 80000010", Haddr_2); end

    // Wait-state hold mid-burst
    step(1'b1, NSEQ, 1'b1, 32'h8400_0000, 32'h1111_1111);
    step(1'b1, SEQ,  1'b1, 32'h8400_0004, 32'hA0A0_0000);
    repeat (3) step(1'b0, SEQ, 1'($urandom), 32'h8400_0008, $urandom);
    total++;
    if (Haddr_1 !== 32'h8400_0004) begin bad++; $error("FAIL ws_hold_haddr_1: got %0h want 84000004", Haddr_1); end
    step(1'b1, IDLE, 1'b0, 32'h0, 32'hA0A0_0004);
    step(1'b1, IDLE, 1'b0, 32'h0, 32'h0);

    // Unmapped access, mapped NONSEQ during ERR1
    step(1'b1, NSEQ, 1'b0, 32'h9000_0000, 32'h0);
    total++;
    if (Hresp !== 2'b01) begin bad++; $error("FAIL ua_hresp_err1: got %0h want 1", Hresp); end
    total++;
    if (Hreadyout_err !== 1'b0) begin bad++; $error("FAIL ua_hready_err1: got %0h want 0", Hreadyout_err); end
    step(1'b1, NSEQ, 1'b0, 32'h8800_0000, 32'h0);
    step(1'b1, IDLE, 1'b0, 32'h0, 32'h0);
    step(1'b1, IDLE, 1'b0, 32'h0, 32'h0);

    // Decode boundaries
    step(1'b1, NSEQ, 1'b0, 32'h83FF_FFFC, 32'h0);
    step(1'b1, NSEQ, 1'b0, 32'h8400_0000, 32'h0);
    step(1'b1, NSEQ, 1'b0, 32'h8BFF_FFFC, 32'h0);
    step(1'b1, NSEQ, 1'b0, 32'h8C00_0000, 32'h0);
    step(1'b1, IDLE, 1'b0, 32'h0, 32'h0);
    step(1'b1, IDLE, 1'b0, 32'h0, 32'h0);

    // Re-entry right after ERR2, with BUSY/IDLE never valid
    step(1'b1, SEQ,  1'b0, 32'h7FFF_FFFC, 32'h0);
    step(1'b1, BUSY, 1'b0, 32'h8000_0000, 32'h0);
    step(1'b1, SEQ,  1'b0, 32'h0000_0000, 32'h0);
    step(1'b1, NSEQ, 1'b0, 32'hFFFF_FFFC, 32'h0);
    step(1'b1, IDLE, 1'b0, 32'h8000_0000, 32'h0);

    // Reset during ERR1
    step(1'b1, NSEQ, 1'b1, 32'h0000_1000, 32'h0);
    do_reset(1);

    // Randomised traffic
    pool = '{32'h8000_0000, 32'h83FF_FF00, 32'h8400_0000, 32'h8800_0100, 32'h8C00_0000, 32'h1000_0000};
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
           pool[$urandom_range(0, 5)] + {$urandom_range(0, 63), 2'b00}, $urandom);
    end

`ifdef AHB_BURST_CHECK_EN
    // INCR4 overrun on the 5th beat
    do_reset(1);
    burst = 3'b011;
    step(1'b1, NSEQ, 1'b1, 32'h8000_0000, 32'h0);
    step(1'b1, SEQ,  1'b1, 32'h8000_0004, 32'h0);
    step(1'b1, SEQ,  1'b1, 32'h8000_0008, 32'h0);
    step(1'b1, SEQ,  1'b1, 32'h8000_000C, 32'h0);
    total++;
    if (Burst_err !== 1'b0) begin bad++; $error("FAIL incr4_ok_4beats: got %0h want 0", Burst_err); end
    step(1'b1, SEQ,  1'b1, 32'h8000_0010, 32'h0);
    total++;
    if (Burst_err !== 1'b1) begin bad++; $error("FAIL incr4_overrun: got %0h want 1", Burst_err); end
    step(1'b1, IDLE, 1'b0, 32'h0, 32'h0);
    total++;
    if (Burst_err !== 1'b1) begin bad++; $error("FAIL incr4_sticky: got %0h want 1", Burst_err); end

    // SEQ without NONSEQ
    do_reset(1);
    step(1'b1, SEQ, 1'b0, 32'h8400_0000, 32'h0);
    total++;
    if (Burst_err !== 1'b1) begin bad++; $error("FAIL orphan_seq: got %0h want 1", Burst_err); end

    // Correct INCR4
    do_reset(1);
    step(1'b1, NSEQ, 1'b0, 32'h8800_0000, 32'h0);
    step(1'b1, SEQ,  1'b0, 32'h8800_0004, 32'h0);
    step(1'b1, SEQ,  1'b0, 32'h8800_0008, 32'h0);
    step(1'b1, SEQ,  1'b0, 32'h8800_000C, 32'h0);
    step(1'b1, IDLE, 1'b0, 32'h0, 32'h0);
    total++;
    if (Burst_err !== 1'b0) begin bad++; $error("FAIL incr4_clean: got %0h want 0", Burst_err); end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
